regfile_onehot_wr: RTL and testbench

- 16-entry, 32-bit general-purpose register file for the 32-bit processor.
- Sits directly downstream of RegisterBank: consumes its 16-bit one-hot write select (decoded destination) together with write-back data.
- Provides two registered read ports for operand fetch.
- Checks the one-hot select for integrity; malformed selects are counted and never corrupt state.

---
 rtl/regfile_onehot_wr.sv | 88 ++++++++
 tb/tb_regfile_onehot_wr.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/regfile_onehot_wr.sv
// 16 x 32-bit register file with one-hot write select, integrity checking and two registered read ports.
// Optional macro REGFILE_BYPASS_EN: same-edge write-to-read forwarding.
module regfile_onehot_wr #(
  parameter int DATA_W    = 32,
  parameter int NUM_REGS  = 16,
  parameter int ADDR_W    = 4,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en,
  input  logic [NUM_REGS-1:0]  wr_sel,
  input  logic [DATA_W-1:0]    wr_data,
  input  logic [ADDR_W-1:0]    rd_addr_a,
  input  logic [ADDR_W-1:0]    rd_addr_b,
  output logic [DATA_W-1:0]    rd_data_a,
  output logic [DATA_W-1:0]    rd_data_b,
  output logic                 sel_err,
  output logic [ERR_CNT_W-1:0] err_count
);

  logic [DATA_W-1:0]    regs_q [NUM_REGS];
  logic [DATA_W-1:0]    regs_d [NUM_REGS];
  logic [DATA_W-1:0]    rd_data_a_q, rd_data_a_d;
  logic [DATA_W-1:0]    rd_data_b_q, rd_data_b_d;
  logic                 sel_err_q, sel_err_d;
  logic [ERR_CNT_W-1:0] err_count_q, err_count_d;

  logic                 sel_onehot;
  logic [ADDR_W-1:0]    wr_idx;
  logic                 wr_hit;

  always_comb begin
    sel_onehot = (wr_sel != '0) && ((wr_sel & (wr_sel - NUM_REGS'(1))) == '0);

    wr_idx = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (wr_sel[i]) wr_idx = ADDR_W'(i);
    end

    // R0 writes are valid requests but are dropped here, so they never forward
    wr_hit = wr_en && sel_onehot && (wr_idx != '0);

    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (wr_hit) regs_d[wr_idx] = wr_data;
    regs_d[0] = '0;

    rd_data_a_d = (rd_addr_a == '0) ? '0 : regs_q[rd_addr_a];
    rd_data_b_d = (rd_addr_b == '0) ? '0 : regs_q[rd_addr_b];
`ifdef REGFILE_BYPASS_EN
    if (wr_hit && (rd_addr_a == wr_idx)) rd_data_a_d = wr_data;
    if (wr_hit && (rd_addr_b == wr_idx)) rd_data_b_d = wr_data;
`else
`endif

    sel_err_d   = wr_en && !sel_onehot;
    err_count_d = err_count_q;
    if (sel_err_d && (err_count_q != '1)) err_count_d = err_count_q + ERR_CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      rd_data_a_q <= '0;
      rd_data_b_q <= '0;
      sel_err_q   <= 1'b0;
      err_count_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
      rd_data_a_q <= rd_data_a_d;
      rd_data_b_q <= rd_data_b_d;
      sel_err_q   <= sel_err_d;
      err_count_q <= err_count_d;
    end
  end

  assign rd_data_a = rd_data_a_q;
  assign rd_data_b = rd_data_b_q;
  assign sel_err   = sel_err_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_regfile_onehot_wr.sv
// Self-checking bench for regfile_onehot_wr: vector table plus scoreboard queue and corner sequences.
module tb_regfile_onehot_wr;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [15:0] wr_sel = '0;
  logic [31:0] wr_data = '0;
  logic [3:0]  rd_addr_a = '0;
  logic [3:0]  rd_addr_b = '0;
  logic [31:0] rd_data_a, rd_data_b;
  logic        sel_err;
  logic [7:0]  err_count;

  int checks = 0;
  int errors = 0;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    logic        we;
    logic [15:0] sel;
    logic [31:0] data;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [31:0] ea;
    logic [31:0] eb;
    logic        ee;
    logic [7:0]  ec;
  } vec_t;

  typedef struct {
    logic [31:0] ea;
    logic [31:0] eb;
    logic        ee;
    logic [7:0]  ec;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[13];

  regfile_onehot_wr dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_sel    (wr_sel),
    .wr_data   (wr_data),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .rd_data_a (rd_data_a),
    .rd_data_b (rd_data_b),
    .sel_err   (sel_err),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus, queue its expected result, compare just after the edge.
  task automatic apply(input vec_t v, input string tag);
    exp_t e;
    wr_en = v.we; wr_sel = v.sel; wr_data = v.data;
    rd_addr_a = v.ra; rd_addr_b = v.rb;
    sb_q.push_back('{ea: v.ea, eb: v.eb, ee: v.ee, ec: v.ec});
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      chk({tag, " scoreboard empty"}, 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      chk({tag, " rd_data_a"}, rd_data_a, e.ea);
      chk({tag, " rd_data_b"}, rd_data_b, e.eb);
      chk({tag, " sel_err"}, {31'd0, sel_err}, {31'd0, e.ee});
      chk({tag, " err_count"}, {24'd0, err_count}, {24'd0, e.ec});
    end
  endtask

  initial begin
    vec_t v;
    int   cnt;

    vecs[0]  = '{1'b1, 16'h0020, 32'h12345678, 4'd0,  4'd0, 32'h0,        32'h0,        1'b0, 8'd0};
    vecs[1]  = '{1'b0, 16'h0000, 32'h0,        4'd5,  4'd5, 32'h12345678, 32'h12345678, 1'b0, 8'd0};
    vecs[2]  = '{1'b1, 16'h0001, 32'hFFFFFFFF, 4'd5,  4'd0, 32'h12345678, 32'h0,        1'b0, 8'd0};
    vecs[3]  = '{1'b0, 16'h0000, 32'h0,        4'd0,  4'd0, 32'h0,        32'h0,        1'b0, 8'd0};
    vecs[4]  = '{1'b1, 16'h0002, 32'h11111111, 4'd5,  4'd5, 32'h12345678, 32'h12345678, 1'b0, 8'd0};
    vecs[5]  = '{1'b1, 16'h0004, 32'h22222222, 4'd1,  4'd5, 32'h11111111, 32'h12345678, 1'b0, 8'd0};
    vecs[6]  = '{1'b1, 16'h0000, 32'hDEADDEAD, 4'd2,  4'd1, 32'h22222222, 32'h11111111, 1'b1, 8'd1};
    vecs[7]  = '{1'b1, 16'h0006, 32'hBADBAD00, 4'd1,  4'd2, 32'h11111111, 32'h22222222, 1'b1, 8'd2};
    vecs[8]  = '{1'b0, 16'h0300, 32'h00000001, 4'd8,  4'd9, 32'h0,        32'h0,        1'b0, 8'd2};
    vecs[9]  = '{1'b0, 16'h0000, 32'h0,        4'd1,  4'd2, 32'h11111111, 32'h22222222, 1'b0, 8'd2};
    vecs[10] = '{1'b1, 16'h8000, 32'hCAFEF00D, 4'd8,  4'd9, 32'h0,        32'h0,        1'b0, 8'd2};
    vecs[11] = '{1'b1, 16'hFFFF, 32'h0BADF00D, 4'd15, 4'd5, 32'hCAFEF00D, 32'h12345678, 1'b1, 8'd3};
    vecs[12] = '{1'b0, 16'h0000, 32'h0,        4'd15, 4'd0, 32'hCAFEF00D, 32'h0,        1'b0, 8'd3};

    #2;
    chk("reset rd_data_a", rd_data_a, 32'h0);
    chk("reset rd_data_b", rd_data_b, 32'h0);
    chk("reset sel_err", {31'd0, sel_err}, 32'h0);
    chk("reset err_count", {24'd0, err_count}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) apply(vecs[i], $sformatf("vec%0d", i));

    // Same-edge collision on reg7
    apply('{1'b1, 16'h0080, 32'hAAAA0000, 4'd0, 4'd0, 32'h0, 32'h0, 1'b0, 8'd3}, "r7 init");
    apply('{1'b0, 16'h0000, 32'h0, 4'd7, 4'd0, 32'hAAAA0000, 32'h0, 1'b0, 8'd3}, "r7 read");
    apply('{1'b1, 16'h0080, 32'h5555FFFF, 4'd7, 4'd3,
            BYP ? 32'h5555FFFF : 32'hAAAA0000, 32'h0, 1'b0, 8'd3}, "collision");
    apply('{1'b0, 16'h0000, 32'h0, 4'd7, 4'd7, 32'h5555FFFF, 32'h5555FFFF, 1'b0, 8'd3}, "post collision");
    // Discarded writes must never forward
    apply('{1'b1, 16'h0081, 32'h01010101, 4'd7, 4'd0, 32'h5555FFFF, 32'h0, 1'b1, 8'd4}, "bad sel no fwd");
    apply('{1'b1, 16'h0001, 32'hFFFFFFFF, 4'd0, 4'd7, 32'h0, 32'h5555FFFF, 1'b0, 8'd4}, "r0 no fwd");

    // Saturation of the error counter
    cnt = 4;
    for (int k = 0; k < 300; k++) begin
      cnt = (cnt < 255) ? cnt + 1 : 255;
      v = '{1'b1, (k[0] ? 16'h0000 : 16'h0C00), 32'(k), 4'd7, 4'd10,
            32'h5555FFFF, 32'h0, 1'b1, 8'(cnt)};
      apply(v, $sformatf("sat%0d", k));
    end
    apply('{1'b1, 16'h0008, 32'hDEADBEEF, 4'd0, 4'd0, 32'h0, 32'h0, 1'b0, 8'd255}, "w r3");
    apply('{1'b1, 16'h0000, 32'h0, 4'd3, 4'd3, 32'hDEADBEEF, 32'hDEADBEEF, 1'b1, 8'd255}, "r3 and bad");

    // Asynchronous reset mid-cycle
    #3;
    rst_n = 1'b0;
    #1;
    chk("async rst rd_data_a", rd_data_a, 32'h0);
    chk("async rst rd_data_b", rd_data_b, 32'h0);
    chk("async rst sel_err", {31'd0, sel_err}, 32'h0);
    chk("async rst err_count", {24'd0, err_count}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    apply('{1'b0, 16'h0000, 32'h0, 4'd3, 4'd7, 32'h0, 32'h0, 1'b0, 8'd0}, "after reset");
    apply('{1'b0, 16'h0000, 32'h0, 4'd15, 4'd5, 32'h0, 32'h0, 1'b0, 8'd0}, "after reset 2");

    chk("scoreboard drained", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule
